// File: rtl/dp_sequencer_pkg.sv
// Shared definitions for the data-processing sequencer: FSM states,
// condition-code values, busA source selects and small helpers.
package dp_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_RSREAD = 3'd2,
      ST_OPREAD = 3'd3,
      ST_EXEC   = 3'd4,
      ST_WB     = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam logic [1:0] BUSA_READ1 = 2'b00;
   localparam logic [1:0] BUSA_ONES  = 2'b01;
   localparam logic [1:0] BUSA_ZERO  = 2'b10;

   // Decoder outputs captured when an instruction is accepted.
   typedef struct packed {
      logic [3:0] cond;
      logic       is_imm;
      logic       imm_shift;
      logic       reg_w;
      logic       set_flags;
      logic       aluhot;
      logic [1:0] special;
      logic [3:0] rn;
      logic [3:0] rd;
      logic [3:0] rm;
      logic [3:0] rs;
      logic [4:0] shamt;
   } fields_t;

   // Register-specified shifts of 32 or more behave like a full shift of 31.
   function automatic logic [4:0] sat_shift(input logic [7:0] rs_val);
      return (rs_val[7:5] != 3'd0) ? 5'd31 : rs_val[4:0];
   endfunction

   // Special input: bit 1 overrides busA, bit 0 chooses zero (1) or all-ones (0).
   function automatic logic [1:0] busa_map(input logic [1:0] special);
      if (!special[1]) return BUSA_READ1;
      return special[0] ? BUSA_ZERO : BUSA_ONES;
   endfunction

endpackage

// File: rtl/dp_sequencer_cond_check.sv
// Combinational condition-field evaluation against the current NZCV flags.
module dp_sequencer_cond_check
   import dp_sequencer_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n, z, c, v;
   assign {n, z, c, v} = nzcv;

   // Decode the 4-bit condition into a single pass/fail.
   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c && !z;
         COND_LS: pass = !c || z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z && (n == v);
         COND_LE: pass = z || (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/dp_sequencer.sv
// Sequences one data-processing instruction: condition check, register
// reads, shifter setup, ALU window, Rd writeback and CPSR update.
module dp_sequencer
   import dp_sequencer_pkg::*;
#(
   parameter int unsigned ALU_LAT = 4
) (
   input  logic        clk1,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   input  logic [3:0]  cpsr_flags,
   input  logic        is_immediate,
   input  logic        do_immediate_shift,
   input  logic        do_reg_w,
   input  logic        do_S,
   input  logic        do_aluhot,
   input  logic [1:0]  do_special_input,
   input  logic [3:0]  do_Rn,
   input  logic [3:0]  do_Rd,
   input  logic [3:0]  do_Rm,
   input  logic [3:0]  do_Rs,
   input  logic [4:0]  do_shifter_count,
   input  logic [7:0]  rs_low,
   output logic [4:0]  address1,
   output logic [4:0]  address2,
   output logic        lat_a,
   output logic        lat_b,
   output logic [1:0]  busa_sel,
   output logic [4:0]  shifter_count,
   output logic        alu_active,
   output logic        wb_sel,
   output logic        reg_w,
   output logic        cpsr_w,
   output logic        busy,
   output logic        done,
   output logic        cond_fail
);

   localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

   state_t     state_q, state_d;
   fields_t    fields_q, fields_d;
   logic [4:0] shift_q, shift_d;
   logic [3:0] cnt_q, cnt_d;
   logic       fail_q, fail_d;
   logic       cond_pass;
   logic       reg_shift;

   // Only the condition field of the raw word matters here; the decoder
   // supplies everything else.
   logic unused_instr;
   assign unused_instr = ^instr[27:0];

   assign reg_shift     = !fields_q.is_imm && !fields_q.imm_shift;
   assign shifter_count = shift_q;

   dp_sequencer_cond_check u_cond (
      .cond (fields_q.cond),
      .nzcv (cpsr_flags),
      .pass (cond_pass)
   );

   // Next-state and Moore outputs; every output is a function of state so
   // an asynchronous reset drops all strobes immediately.
   always_comb begin
      state_d     = state_q;
      fields_d    = fields_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      fail_d      = fail_q;
      instr_ready = 1'b0;
      address1    = 5'd0;
      address2    = 5'd0;
      lat_a       = 1'b0;
      lat_b       = 1'b0;
      busa_sel    = BUSA_READ1;
      alu_active  = 1'b0;
      wb_sel      = 1'b0;
      reg_w       = 1'b0;
      cpsr_w      = 1'b0;
      done        = 1'b0;
      cond_fail   = 1'b0;
      busy        = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               fields_d.cond      = instr[31:28];
               fields_d.is_imm    = is_immediate;
               fields_d.imm_shift = do_immediate_shift;
               fields_d.reg_w     = do_reg_w;
               fields_d.set_flags = do_S;
               fields_d.aluhot    = do_aluhot;
               fields_d.special   = do_special_input;
               fields_d.rn        = do_Rn;
               fields_d.rd        = do_Rd;
               fields_d.rm        = do_Rm;
               fields_d.rs        = do_Rs;
               fields_d.shamt     = do_shifter_count;
               fail_d             = 1'b0;
               state_d            = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (!cond_pass) begin
               fail_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               address1 = {1'b0, fields_q.rn};
               if (reg_shift) begin
                  address2 = {1'b0, fields_q.rs};
                  state_d  = ST_RSREAD;
               end else begin
                  address2 = {1'b0, fields_q.rm};
                  shift_d  = fields_q.shamt;
                  state_d  = ST_OPREAD;
               end
            end
         end
         ST_RSREAD: begin
            address1 = {1'b0, fields_q.rn};
            address2 = {1'b0, fields_q.rm};
            shift_d  = sat_shift(rs_low);
            state_d  = ST_OPREAD;
         end
         ST_OPREAD: begin
            address1 = {1'b0, fields_q.rn};
            address2 = {1'b0, fields_q.rm};
            lat_a    = 1'b1;
            lat_b    = 1'b1;
            busa_sel = busa_map(fields_q.special);
            cnt_d    = fields_q.aluhot ? LAT_M1 : 4'd0;
            state_d  = ST_EXEC;
         end
         ST_EXEC: begin
            alu_active = fields_q.aluhot;
            wb_sel     = fields_q.aluhot;
            if (cnt_q == 4'd0) state_d = ST_WB;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_WB: begin
            address1 = {1'b0, fields_q.rd};
            wb_sel   = fields_q.aluhot;
            reg_w    = fields_q.reg_w;
            cpsr_w   = fields_q.set_flags && fields_q.aluhot;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            cond_fail = fail_q;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control state: FSM, ALU window counter, shift amount and fail flag.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         shift_q <= 5'd0;
         cnt_q   <= 4'd0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         fail_q  <= fail_d;
      end
   end

   // Latched decoder fields; only meaningful while busy, so no reset.
   always_ff @(posedge clk1) begin
      fields_q <= fields_d;
   end

endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer: directed cases plus randomized
// instructions compared against a cycle-schedule reference model.
module tb_dp_sequencer;

   localparam int unsigned LAT = 4;

   logic        clk1 = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic [3:0]  cpsr_flags;
   logic        is_immediate, do_immediate_shift, do_reg_w, do_S, do_aluhot;
   logic [1:0]  do_special_input;
   logic [3:0]  do_Rn, do_Rd, do_Rm, do_Rs;
   logic [4:0]  do_shifter_count;
   logic [7:0]  rs_low = 8'd0;
   logic [4:0]  address1, address2;
   logic        lat_a, lat_b;
   logic [1:0]  busa_sel;
   logic [4:0]  shifter_count;
   logic        alu_active, wb_sel, reg_w, cpsr_w, busy, done, cond_fail;

   logic [7:0]  rf [32];
   int          n_cmp = 0;
   int          n_bad = 0;

   typedef struct {
      logic [3:0] cond;
      logic [3:0] flags;
      logic       is_imm, imm_shift, reg_w, s, aluhot;
      logic [1:0] special;
      logic [3:0] rn, rd, rm, rs;
      logic [4:0] shamt;
   } ins_t;

   dp_sequencer #(.ALU_LAT(LAT)) dut (
      .clk1(clk1), .rst(rst), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .cpsr_flags(cpsr_flags),
      .is_immediate(is_immediate), .do_immediate_shift(do_immediate_shift),
      .do_reg_w(do_reg_w), .do_S(do_S), .do_aluhot(do_aluhot),
      .do_special_input(do_special_input), .do_Rn(do_Rn), .do_Rd(do_Rd),
      .do_Rm(do_Rm), .do_Rs(do_Rs), .do_shifter_count(do_shifter_count),
      .rs_low(rs_low), .address1(address1), .address2(address2),
      .lat_a(lat_a), .lat_b(lat_b), .busa_sel(busa_sel),
      .shifter_count(shifter_count), .alu_active(alu_active), .wb_sel(wb_sel),
      .reg_w(reg_w), .cpsr_w(cpsr_w), .busy(busy), .done(done),
      .cond_fail(cond_fail)
   );

   always #5 clk1 = ~clk1;

   // Register bank model: read2 data appears one cycle after address2.
   always @(posedge clk1) rs_low <= rf[address2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Architectural rule: pairs of conditions, odd code is the inverse.
   function automatic bit ref_pass(input ins_t t);
      bit n, z, c, v, base;
      {n, z, c, v} = t.flags;
      if (t.cond == 4'hE) return 1'b1;
      if (t.cond == 4'hF) return 1'b0;
      case (t.cond[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b0;
      endcase
      return t.cond[0] ? !base : base;
   endfunction

   function automatic ins_t rand_ins();
      ins_t t;
      t.cond      = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom);
      t.flags     = 4'($urandom);
      t.is_imm    = 1'($urandom);
      t.imm_shift = 1'($urandom);
      t.reg_w     = 1'($urandom);
      t.s         = 1'($urandom);
      t.aluhot    = 1'($urandom);
      t.special   = 2'($urandom);
      t.rn        = 4'($urandom);
      t.rd        = 4'($urandom);
      t.rm        = 4'($urandom);
      t.rs        = 4'($urandom);
      t.shamt     = 5'($urandom);
      return t;
   endfunction

   task automatic drive_fields(input ins_t t);
      instr              = {t.cond, 28'($urandom)};
      is_immediate       = t.is_imm;
      do_immediate_shift = t.imm_shift;
      do_reg_w           = t.reg_w;
      do_S               = t.s;
      do_aluhot          = t.aluhot;
      do_special_input   = t.special;
      do_Rn              = t.rn;
      do_Rd              = t.rd;
      do_Rm              = t.rm;
      do_Rs              = t.rs;
      do_shifter_count   = t.shamt;
   endtask

   // Called just after a rising edge; returns the cycle in which done was seen.
   task automatic run_instr(input ins_t t, input bit hold, output int obs_done);
      ins_t       junk;
      bit         pass;
      int         r, e, lat_k, wb_k, done_k;
      logic [4:0] exp_sh;
      logic [1:0] exp_bs;
      logic [7:0] rsv;
      pass   = ref_pass(t);
      r      = (!t.is_imm && !t.imm_shift) ? 1 : 0;
      e      = t.aluhot ? LAT : 1;
      lat_k  = 2 + r;
      wb_k   = 3 + r + e;
      done_k = pass ? 4 + r + e : 2;
      rsv    = rf[{1'b0, t.rs}];
      exp_sh = (r == 1) ? ((rsv >= 8'd32) ? 5'd31 : rsv[4:0]) : t.shamt;
      exp_bs = t.special[1] ? (t.special[0] ? 2'b10 : 2'b01) : 2'b00;
      cpsr_flags  = t.flags;
      drive_fields(t);
      instr_valid = 1'b1;
      @(negedge clk1);
      chk("idle_ready", 32'(instr_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      obs_done = -1;
      for (int k = 1; k <= done_k; k++) begin
         @(posedge clk1);
         #1;
         instr_valid = hold && (k < done_k);
         junk = rand_ins();
         drive_fields(junk);
         @(negedge clk1);
         if (done && obs_done < 0) obs_done = k;
         chk("busy", 32'(busy), 32'd1);
         chk("ready", 32'(instr_ready), 32'd0);
         chk("done", 32'(done), 32'(k == done_k));
         chk("cond_fail", 32'(cond_fail), 32'(!pass && k == done_k));
         chk("lat_a", 32'(lat_a), 32'(pass && k == lat_k));
         chk("lat_b", 32'(lat_b), 32'(pass && k == lat_k));
         chk("alu_active", 32'(alu_active), 32'(pass && t.aluhot && k > lat_k && k < wb_k));
         chk("reg_w", 32'(reg_w), 32'(pass && t.reg_w && k == wb_k));
         chk("cpsr_w", 32'(cpsr_w), 32'(pass && t.s && t.aluhot && k == wb_k));
         if (pass && k == 1) begin
            chk("dec_addr1", 32'(address1), 32'(t.rn));
            chk("dec_addr2", 32'(address2), (r == 1) ? 32'(t.rs) : 32'(t.rm));
         end
         if (pass && k == lat_k) begin
            chk("busa_sel", 32'(busa_sel), 32'(exp_bs));
            chk("shifter_count", 32'(shifter_count), 32'(exp_sh));
            chk("op_addr1", 32'(address1), 32'(t.rn));
            chk("op_addr2", 32'(address2), 32'(t.rm));
         end
         if (pass && k == wb_k) begin
            chk("wb_addr1", 32'(address1), 32'(t.rd));
            chk("wb_sel", 32'(wb_sel), 32'(t.aluhot));
         end
      end
      @(posedge clk1);
      #1;
      @(negedge clk1);
      chk("post_ready", 32'(instr_ready), 32'd1);
      chk("post_busy", 32'(busy), 32'd0);
      @(posedge clk1);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ins_t t;
      int   od;
      rst = 1'b1;
      instr_valid = 1'b0;
      cpsr_flags = 4'd0;
      drive_fields(rand_ins());
      for (int i = 0; i < 32; i++) rf[i] = 8'($urandom);
      rf[2] = 8'h23;
      repeat (2) @(posedge clk1);
      @(negedge clk1);
      chk("rst_ready", 32'(instr_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_strobes", {25'd0, lat_a, lat_b, alu_active, reg_w, cpsr_w, done, cond_fail}, 32'd0);
      chk("rst_sel", {20'd0, busa_sel, wb_sel, shifter_count, 4'd0}, 32'd0);
      chk("rst_addr", {22'd0, address1, address2}, 32'd0);
      rst = 1'b0;
      @(posedge clk1);
      #1;

      // ADDS R0,R0,#0x0F, AL, flags 0
      t = '{cond:4'hE, flags:4'h0, is_imm:1, imm_shift:0, reg_w:1, s:1, aluhot:1,
            special:2'b00, rn:4'd0, rd:4'd0, rm:4'hF, rs:4'd0, shamt:5'd0};
      run_instr(t, 1'b0, od);
      chk("lat_adds", 32'(od), 32'd8);

      // Register-specified shift, Rs=2 holding 0x23 saturates to 31
      t = '{cond:4'hE, flags:4'h0, is_imm:0, imm_shift:0, reg_w:1, s:0, aluhot:1,
            special:2'b00, rn:4'd1, rd:4'd3, rm:4'd4, rs:4'd2, shamt:5'd7};
      run_instr(t, 1'b0, od);
      chk("lat_regshift", 32'(od), 32'd9);

      // EQ with Z=0 fails
      t = '{cond:4'h0, flags:4'h0, is_imm:1, imm_shift:0, reg_w:1, s:1, aluhot:1,
            special:2'b00, rn:4'd5, rd:4'd6, rm:4'd7, rs:4'd0, shamt:5'd0};
      run_instr(t, 1'b0, od);
      chk("lat_condfail", 32'(od), 32'd2);

      // MOV with S: shifter result, no CPSR write
      t = '{cond:4'hE, flags:4'h0, is_imm:1, imm_shift:0, reg_w:1, s:1, aluhot:0,
            special:2'b00, rn:4'd0, rd:4'd15, rm:4'd9, rs:4'd0, shamt:5'd4};
      run_instr(t, 1'b0, od);
      chk("lat_mov", 32'(od), 32'd5);

      // busA overrides: zero and all-ones, immediate shift amount
      t = '{cond:4'hE, flags:4'h0, is_imm:0, imm_shift:1, reg_w:1, s:0, aluhot:1,
            special:2'b11, rn:4'd2, rd:4'd3, rm:4'd4, rs:4'd0, shamt:5'd13};
      run_instr(t, 1'b0, od);
      t.special = 2'b10;
      run_instr(t, 1'b0, od);

      // instr_valid held high while busy: only one instruction is taken
      t = '{cond:4'hE, flags:4'h0, is_imm:1, imm_shift:0, reg_w:1, s:1, aluhot:1,
            special:2'b00, rn:4'd8, rd:4'd9, rm:4'd10, rs:4'd0, shamt:5'd2};
      run_instr(t, 1'b1, od);
      chk("lat_hold", 32'(od), 32'd8);

      // Asynchronous reset in the middle of the ALU window
      drive_fields(t);
      cpsr_flags  = t.flags;
      instr_valid = 1'b1;
      @(posedge clk1);
      #1;
      instr_valid = 1'b0;
      repeat (3) @(posedge clk1);
      #2;
      chk("pre_rst_alu", 32'(alu_active), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("async_alu", 32'(alu_active), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_ready", 32'(instr_ready), 32'd1);
      @(posedge clk1);
      @(negedge clk1);
      chk("rst_no_wb", {30'd0, reg_w, cpsr_w}, 32'd0);
      rst = 1'b0;
      @(posedge clk1);
      #1;
      t.rd = 4'd11;
      run_instr(t, 1'b0, od);
      chk("lat_after_rst", 32'(od), 32'd8);

      for (int i = 0; i < 40; i++) begin
         t = rand_ins();
         run_instr(t, 1'($urandom_range(0, 3) == 0), od);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
